// File: rtl/sh_dump_pkg.sv
// Shared definitions for the shadow-dump sequencer: FSM state encoding,
// chain index width and default phase/timeout cycle counts.
package sh_dump_pkg;

  localparam int CHAIN_IDX_W    = 5;
  localparam int TMR_W          = 12;
  localparam int SH_RST_CYC_DEF = 4;
  localparam int CAP_CYC_DEF    = 1;
  localparam int TIMEOUT_DEF    = 4095;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SHRST = 3'd1,
    ST_CAPT  = 3'd2,
    ST_SEL   = 3'd3,
    ST_DUMP  = 3'd4,
    ST_FLUSH = 3'd5,
    ST_FIN   = 3'd6
  } state_e;

endpackage

// File: rtl/sh_dump_ctrl_packer.sv
// sh_word_packer: collects serial chain bits LSB-first into a word and hands
// full or flushed words to a registered valid/ready output stage.
//   clear          discard the partially filled word
//   bit_valid/in   one chain bit, stored at position cnt
//   flush_req      emit the partial word (last=1, nbits=cnt) once any full
//                  word has moved out; flush_ack marks that hand-off
//   chain_in       chain index tagged onto loaded words
//   full_next /
//   out_valid_next next-cycle packer-full and output-occupied, for stalling
//   out_*          output register
module sh_word_packer
  import sh_dump_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   bit_valid,
  input  logic                   bit_in,
  input  logic                   flush_req,
  input  logic [CHAIN_IDX_W-1:0] chain_in,
  input  logic                   out_ready,
  output logic                   full_next,
  output logic                   out_valid_next,
  output logic                   flush_ack,
  output logic                   out_valid,
  output logic [WORD_W-1:0]      out_data,
  output logic [CHAIN_IDX_W-1:0] out_chain,
  output logic                   out_last,
  output logic [CNT_W-1:0]       out_nbits
);

  localparam int IDX_W = $clog2(WORD_W);

  logic [WORD_W-1:0]      sh_q, sh_d, base_sh;
  logic [CNT_W-1:0]       cnt_q, cnt_d, base_cnt;
  logic                   out_valid_q, out_valid_d;
  logic [WORD_W-1:0]      out_data_q, out_data_d;
  logic [CHAIN_IDX_W-1:0] out_chain_q, out_chain_d;
  logic                   out_last_q, out_last_d;
  logic [CNT_W-1:0]       out_nbits_q, out_nbits_d;
  logic                   full, can_load, move_full, move_flush, move;

  always_comb begin
    full       = (cnt_q == CNT_W'(WORD_W));
    can_load   = !out_valid_q || out_ready;
    move_full  = full && can_load && !clear;
    // A pending full word always leaves first, so a flush after a chain that
    // ended on a word boundary yields an nbits=0 closing word.
    move_flush = flush_req && !full && can_load && !clear;
    move       = move_full || move_flush;

    base_sh  = move ? '0 : sh_q;
    base_cnt = move ? '0 : cnt_q;
    sh_d     = base_sh;
    cnt_d    = base_cnt;
    if (clear) begin
      sh_d  = '0;
      cnt_d = '0;
    end else if (bit_valid) begin
      sh_d[base_cnt[IDX_W-1:0]] = bit_in;
      cnt_d = base_cnt + CNT_W'(1);
    end

    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chain_d = out_chain_q;
    out_last_d  = out_last_q;
    out_nbits_d = out_nbits_q;
    if (move) begin
      out_valid_d = 1'b1;
      out_data_d  = sh_q;
      out_chain_d = chain_in;
      out_last_d  = move_flush;
      out_nbits_d = cnt_q;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    full_next      = (cnt_d == CNT_W'(WORD_W));
    out_valid_next = out_valid_d;
    flush_ack      = move_flush;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q        <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chain_q <= '0;
      out_last_q  <= 1'b0;
      out_nbits_q <= '0;
    end else begin
      sh_q        <= sh_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chain_q <= out_chain_d;
      out_last_q  <= out_last_d;
      out_nbits_q <= out_nbits_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chain = out_chain_q;
  assign out_last  = out_last_q;
  assign out_nbits = out_nbits_q;

endmodule

// File: rtl/sh_dump_ctrl.sv
// sh_dump_ctrl: host-commanded shadow-capture sequencer. Pulses sh_rst, then
// c_en, then drains each chain of the latched mask in ascending order,
// streaming packed 32-bit words on dout_* (valid/ready).
//   cmd_*        start/mask in; busy, done pulse, sticky timeout error out
//   sh_rst/c_en/dump_en, sh_out*  shadow-chain interface (one active at a time)
//   dout_*       packed word stream: data (first bit in bit 0), chain, last, nbits
module sh_dump_ctrl
  import sh_dump_pkg::*;
#(
  parameter int NCHAIN     = 32,
  parameter int WORD_W     = 32,
  parameter int SH_RST_CYC = SH_RST_CYC_DEF,
  parameter int CAP_CYC    = CAP_CYC_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic                   gclk,
  input  logic                   reset_l,
  input  logic                   cmd_start,
  input  logic [NCHAIN-1:0]      cmd_mask,
  output logic                   cmd_busy,
  output logic                   cmd_done,
  output logic                   cmd_err,
  output logic [CHAIN_IDX_W-1:0] err_chain,
  output logic                   sh_rst,
  output logic                   c_en,
  output logic [NCHAIN-1:0]      dump_en,
  input  logic [NCHAIN-1:0]      sh_out,
  input  logic [NCHAIN-1:0]      sh_out_vld,
  input  logic [NCHAIN-1:0]      sh_out_done,
  output logic                   dout_valid,
  input  logic                   dout_ready,
  output logic [WORD_W-1:0]      dout_data,
  output logic [CHAIN_IDX_W-1:0] dout_chain,
  output logic                   dout_last,
  output logic [5:0]             dout_nbits
);

  state_e                 state_q, state_d;
  logic [NCHAIN-1:0]      mask_q, mask_d;
  logic [CHAIN_IDX_W-1:0] sel_q, sel_d, low_idx;
  logic [TMR_W-1:0]       tmr_q, tmr_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic [CHAIN_IDX_W-1:0] err_chain_q, err_chain_d;
  logic                   sh_rst_q, sh_rst_d;
  logic                   c_en_q, c_en_d;
  logic [NCHAIN-1:0]      dump_en_q, dump_en_d;
  logic                   found, bit_acc, chain_done;
  logic                   pk_clear, pk_flush, pk_flush_ack;
  logic                   pk_full_next, pk_out_valid_next;

  always_comb begin
    found   = 1'b0;
    low_idx = '0;
    for (int unsigned i = 0; i < NCHAIN; i++) begin
      if (!found && mask_q[i]) begin
        found   = 1'b1;
        low_idx = CHAIN_IDX_W'(i);
      end
    end

    // dump_en_q is only ever nonzero in DUMP, so these imply that state.
    bit_acc    = dump_en_q[sel_q] && sh_out_vld[sel_q];
    chain_done = dump_en_q[sel_q] && sh_out_done[sel_q];

    state_d     = state_q;
    mask_d      = mask_q;
    sel_d       = sel_q;
    tmr_d       = tmr_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = err_q;
    err_chain_d = err_chain_q;
    pk_clear    = 1'b0;
    pk_flush    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_start) begin
          mask_d      = cmd_mask;
          err_d       = 1'b0;
          err_chain_d = '0;
          busy_d      = 1'b1;
          tmr_d       = '0;
          state_d     = ST_SHRST;
        end
      end
      ST_SHRST: begin
        if (tmr_q == TMR_W'(SH_RST_CYC - 1)) begin
          tmr_d   = '0;
          state_d = ST_CAPT;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      ST_CAPT: begin
        if (tmr_q == TMR_W'(CAP_CYC - 1)) begin
          tmr_d   = '0;
          state_d = ST_SEL;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      ST_SEL: begin
        if (!found) begin
          state_d = ST_FIN;
        end else begin
          sel_d   = low_idx;
          mask_d  = mask_q & (mask_q - NCHAIN'(1));
          tmr_d   = '0;
          state_d = ST_DUMP;
        end
      end
      ST_DUMP: begin
        if (chain_done) begin
          state_d = ST_FLUSH;
        end else if (bit_acc || dump_en_q == '0) begin
          tmr_d = '0;
        end else if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
          err_d       = 1'b1;
          err_chain_d = sel_q;
          pk_clear    = 1'b1;
          state_d     = ST_FIN;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      ST_FLUSH: begin
        pk_flush = 1'b1;
        if (pk_flush_ack) state_d = ST_SEL;
      end
      ST_FIN: begin
        if (!dout_valid) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next state. dump_en is withheld for a
    // cycle in which the packer will be full and the output still occupied.
    sh_rst_d  = (state_d == ST_SHRST);
    c_en_d    = (state_d == ST_CAPT);
    dump_en_d = '0;
    if (state_d == ST_DUMP && !(pk_full_next && pk_out_valid_next))
      dump_en_d[sel_d] = 1'b1;
  end

  always_ff @(posedge gclk or negedge reset_l) begin
    if (!reset_l) begin
      state_q     <= ST_IDLE;
      mask_q      <= '0;
      sel_q       <= '0;
      tmr_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_chain_q <= '0;
      sh_rst_q    <= 1'b0;
      c_en_q      <= 1'b0;
      dump_en_q   <= '0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      sel_q       <= sel_d;
      tmr_q       <= tmr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_chain_q <= err_chain_d;
      sh_rst_q    <= sh_rst_d;
      c_en_q      <= c_en_d;
      dump_en_q   <= dump_en_d;
    end
  end

  sh_word_packer #(
    .WORD_W (WORD_W),
    .CNT_W  (6)
  ) u_packer (
    .clk            (gclk),
    .rst_n          (reset_l),
    .clear          (pk_clear),
    .bit_valid      (bit_acc),
    .bit_in         (sh_out[sel_q]),
    .flush_req      (pk_flush),
    .chain_in       (sel_q),
    .out_ready      (dout_ready),
    .full_next      (pk_full_next),
    .out_valid_next (pk_out_valid_next),
    .flush_ack      (pk_flush_ack),
    .out_valid      (dout_valid),
    .out_data       (dout_data),
    .out_chain      (dout_chain),
    .out_last       (dout_last),
    .out_nbits      (dout_nbits)
  );

  assign cmd_busy  = busy_q;
  assign cmd_done  = done_q;
  assign cmd_err   = err_q;
  assign err_chain = err_chain_q;
  assign sh_rst    = sh_rst_q;
  assign c_en      = c_en_q;
  assign dump_en   = dump_en_q;

endmodule
